// File: rtl/pingpong_fmap_buf_ctrl_pkg.sv
// Shared types and defaults for the ping-pong feature-map buffer controller.
package pingpong_fmap_buf_ctrl_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ADDRWIDTH = 8;
  localparam int DEF_DEPTH     = 256;

  // Selects one of the two RAM banks.
  typedef logic bank_sel_t;

  // One full flag per bank, bit index equals bank number.
  typedef logic [1:0] bank_full_t;

  // One-hot mask for a bank inside a bank_full_t vector.
  function automatic bank_full_t bank_onehot(input bank_sel_t bank);
    bank_full_t mask;
    case (bank)
      1'b0:    mask = 2'b01;
      1'b1:    mask = 2'b10;
      default: mask = 2'b00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pingpong_fmap_buf_ctrl_ptr.sv
// Bank select plus address counter. Advances through 0..DEPTH-1 and then
// wraps to address 0 of the other bank.
module pingpong_ptr
  import pingpong_fmap_buf_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 advance_i,
  output logic                 bank_o,
  output logic [ADDRWIDTH-1:0] addr_o,
  output logic                 at_last_o,
  output logic                 wrap_o
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ZERO = {ADDRWIDTH{1'b0}};

  bank_sel_t            bank_q, bank_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;

  assign bank_o    = bank_q;
  assign addr_o    = addr_q;
  assign at_last_o = (addr_q == LAST_ADDR);
  assign wrap_o    = advance_i & at_last_o;

  // Next pointer: step the address, or switch bank at the end of a frame.
  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    if (advance_i) begin
      if (at_last_o) begin
        bank_d = ~bank_q;
        addr_d = ADDR_ZERO;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Pointer state with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      bank_q <= 1'b0;
      addr_q <= ADDR_ZERO;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/pingpong_fmap_buf_ctrl.sv
// Ping-pong controller for two external simple-dual-port RAM banks: the
// producer fills one bank while the consumer drains the other.
module pingpong_fmap_buf_ctrl
  import pingpong_fmap_buf_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 ram0_wea,
  output logic                 ram1_wea,
  output logic [ADDRWIDTH-1:0] ram0_addra,
  output logic [ADDRWIDTH-1:0] ram1_addra,
  output logic [WIDTH-1:0]     ram0_dia,
  output logic [WIDTH-1:0]     ram1_dia,
  output logic [ADDRWIDTH-1:0] ram0_addrb,
  output logic [ADDRWIDTH-1:0] ram1_addrb,
  input  logic [WIDTH-1:0]     ram0_dob,
  input  logic [WIDTH-1:0]     ram1_dob,
  output logic [1:0]           bank_full
);

  logic                 clr_s;
  logic                 wr_accept_s, rd_fire_s;
  logic                 wr_bank_s, rd_bank_s;
  logic [ADDRWIDTH-1:0] wr_addr_s, rd_addr_s;
  logic                 wr_at_last_s, wr_wrap_s;
  logic                 rd_at_last_s, rd_wrap_s;
  bank_full_t           full_q, full_d;
  bank_full_t           set_mask_s, clr_mask_s;

  // rst and flush have identical effect; both also gate every handshake.
  assign clr_s = rst | flush;

  assign in_ready    = ~clr_s & ~full_q[wr_bank_s];
  assign out_valid   = ~clr_s & full_q[rd_bank_s];
  assign wr_accept_s = in_valid & in_ready;
  assign rd_fire_s   = out_valid & out_ready;

  pingpong_ptr #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_wr_ptr (
    .clk_i     (clk),
    .clr_i     (clr_s),
    .advance_i (wr_accept_s),
    .bank_o    (wr_bank_s),
    .addr_o    (wr_addr_s),
    .at_last_o (wr_at_last_s),
    .wrap_o    (wr_wrap_s)
  );

  pingpong_ptr #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_rd_ptr (
    .clk_i     (clk),
    .clr_i     (clr_s),
    .advance_i (rd_fire_s),
    .bank_o    (rd_bank_s),
    .addr_o    (rd_addr_s),
    .at_last_o (rd_at_last_s),
    .wrap_o    (rd_wrap_s)
  );

  // Write side: only the bank being filled sees a write enable. Address and
  // data buses are shared, which is harmless with wea low on the idle bank.
  assign ram0_wea   = wr_accept_s & (wr_bank_s == 1'b0);
  assign ram1_wea   = wr_accept_s & (wr_bank_s == 1'b1);
  assign ram0_addra = wr_addr_s;
  assign ram1_addra = wr_addr_s;
  assign ram0_dia   = in_data;
  assign ram1_dia   = in_data;

  // Read side: asynchronous RAM read, so data is presented in the same cycle.
  assign ram0_addrb = rd_addr_s;
  assign ram1_addrb = rd_addr_s;
  assign out_data   = rd_bank_s ? ram1_dob : ram0_dob;
  assign out_last   = out_valid & rd_at_last_s;

  assign bank_full  = full_q;

  // Completing writer marks its bank full, completing reader frees its bank;
  // they always refer to different banks so both can apply in one cycle.
  always_comb begin
    set_mask_s = 2'b00;
    clr_mask_s = 2'b00;
    if (wr_wrap_s & wr_at_last_s) begin
      set_mask_s = bank_onehot(wr_bank_s);
    end else begin
      set_mask_s = 2'b00;
    end
    if (rd_wrap_s) begin
      clr_mask_s = bank_onehot(rd_bank_s);
    end else begin
      clr_mask_s = 2'b00;
    end
    full_d = (full_q | set_mask_s) & ~clr_mask_s;
  end

  // Per-bank full flags, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_pingpong_fmap_buf_ctrl.sv
// Self-checking bench for pingpong_fmap_buf_ctrl with DEPTH=4 and a
// behavioural RAM model for both banks.
module tb_pingpong_fmap_buf_ctrl;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = 4'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          ram0_wea, ram1_wea;
  logic [AW-1:0] ram0_addra, ram1_addra, ram0_addrb, ram1_addrb;
  logic [W-1:0]  ram0_dia, ram1_dia, ram0_dob, ram1_dob;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  pingpong_fmap_buf_ctrl #(.WIDTH(W), .ADDRWIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .ram0_wea(ram0_wea), .ram1_wea(ram1_wea),
    .ram0_addra(ram0_addra), .ram1_addra(ram1_addra),
    .ram0_dia(ram0_dia), .ram1_dia(ram1_dia),
    .ram0_addrb(ram0_addrb), .ram1_addrb(ram1_addrb),
    .ram0_dob(ram0_dob), .ram1_dob(ram1_dob),
    .bank_full(bank_full)
  );

  // External RAM banks: synchronous write, asynchronous read.
  logic [W-1:0] mem0 [0:255];
  logic [W-1:0] mem1 [0:255];

  always @(posedge clk) begin
    if (ram0_wea) mem0[ram0_addra] <= ram0_dia;
    if (ram1_wea) mem1[ram1_addra] <= ram1_dia;
  end

  assign ram0_dob = mem0[ram0_addrb];
  assign ram1_dob = mem1[ram1_addrb];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [1:0]   full_m = 2'b00;
  int           wb = 0, rb = 0, wc = 0, rc = 0;
  logic [W-1:0] sb[$];
  logic         obs_ov;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs, update model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [W-1:0] din, input logic ordy);
    logic         exp_ir, exp_ov, acc, rdf;
    logic [W-1:0] exp_d;
    int           wb_o, rb_o;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    exp_ir = !(r || f) && !full_m[wb];
    exp_ov = !(r || f) && full_m[rb];
    acc    = iv && exp_ir;
    rdf    = ordy && exp_ov;
    check_eq("in_ready",  {31'd0, in_ready},  {31'd0, exp_ir});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check_eq("out_last",  {31'd0, out_last},  {31'd0, exp_ov && (rc == D-1)});
    check_eq("bank_full", {30'd0, bank_full}, {30'd0, full_m});
    check_eq("wea", {30'd0, ram1_wea, ram0_wea},
             {30'd0, (acc ? ((wb == 1) ? 2'b10 : 2'b01) : 2'b00)});
    check_eq("dia", {28'd0, ((wb == 1) ? ram1_dia : ram0_dia)}, {28'd0, din});
    if (acc) check_eq("addra", {24'd0, ((wb == 1) ? ram1_addra : ram0_addra)}, wc);
    if (exp_ov) check_eq("addrb", {24'd0, ((rb == 1) ? ram1_addrb : ram0_addrb)}, rc);
    if (rdf) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        exp_d = sb.pop_front();
        check_eq("out_data", {28'd0, out_data}, {28'd0, exp_d});
      end
    end
    obs_ov = out_valid;
    if (r || f) begin
      full_m = 2'b00; wb = 0; rb = 0; wc = 0; rc = 0;
      sb.delete();
    end else begin
      wb_o = wb; rb_o = rb;
      if (acc) begin
        sb.push_back(din);
        if (wc == D-1) begin full_m[wb_o] = 1'b1; wb = 1 - wb; wc = 0; end
        else wc++;
      end
      if (rdf) begin
        if (rc == D-1) begin full_m[rb_o] = 1'b0; rb = 1 - rb; rc = 0; end
        else rc++;
      end
    end
  endtask

  int           bubbles;
  logic [W-1:0] held_data;
  logic         held_last;
  logic [AW-1:0] held_addr;

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("rst_addra", {24'd0, ram0_addra}, 32'd0);
    check_eq("rst_addrb", {24'd0, ram0_addrb}, 32'd0);

    // 1: fill bank 0 with 0..3, then drain it
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, W'(i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t1_full", {30'd0, bank_full}, 32'd1);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t1_empty", {30'd0, bank_full}, 32'd0);

    // 2: both banks full, then drain one and resume
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 2*D; i++) step(1'b0, 1'b0, 1'b1, W'(i + 5), 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'hf, 1'b0);
    check_eq("t2_full11", {30'd0, bank_full}, 32'd3);
    check_eq("t2_stall", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
    check_eq("t2_resume_wea0", {31'd0, ram0_wea}, 32'd1);

    // 3: simultaneous write and read completion on different banks
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, W'(i + 2), 1'b0);
    for (int i = 0; i < D-1; i++) step(1'b0, 1'b0, 1'b1, W'(i + 8), 1'b0);
    for (int i = 0; i < D-1; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'hc, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t3_full10", {30'd0, bank_full}, 32'd2);
    step(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    check_eq("t3_wr_bank0", {31'd0, ram0_wea}, 32'd1);

    // 4: streaming five frames
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    bubbles = 0;
    for (int i = 0; i < 6*D; i++) begin
      step(1'b0, 1'b0, (i < 5*D), W'(i), 1'b1);
      if (i >= D && !obs_ov) bubbles++;
    end
    check_eq("t4_bubbles", bubbles, 0);
    check_eq("t4_drained", sb.size(), 0);

    // 5: flush mid-frame
    step(1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h5, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t5_full", {30'd0, bank_full}, 32'd0);
    check_eq("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t5_out_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 4'h6, 1'b0);
    check_eq("t5_addr0", {24'd0, ram0_addra}, 32'd0);

    // 6: stall stability with the read pointer on the last word
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b1, W'(i + 10), 1'b0);
    for (int i = 0; i < D-1; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    held_data = out_data;
    held_last = out_last;
    held_addr = ram0_addrb;
    check_eq("t6_last", {31'd0, held_last}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, W'(i), 1'b0);
      check_eq("t6_data", {28'd0, out_data}, {28'd0, held_data});
      check_eq("t6_olast", {31'd0, out_last}, {31'd0, held_last});
      check_eq("t6_addr", {24'd0, ram0_addrb}, {24'd0, held_addr});
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t6_done", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
